branch_resolver: RTL
====================

BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 Parameter DEPTH, default 4: number of in-flight branch entries; power of two, 2..16.
REQ-002 Parameter CW, default 16: width of the statistics counters.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port fetch_branch, input, 1: front end has a new branch needing a prediction this cycle.
REQ-006 Port pred_request, output, 1: request strobe to the predictor.
REQ-007 Port prediction, input, 1: predictor's registered prediction; valid the cycle after pred_request.
REQ-008 Port exec_valid, input, 1: execute stage resolves the oldest in-flight branch this cycle.
REQ-009 Port exec_taken, input, 1: actual outcome of that branch; 1 = taken.
REQ-010 Port result, output, 1: registered one-cycle pulse telling the predictor to train.
REQ-011 Port taken, output, 1: registered training outcome; valid while result=1.
REQ-012 Port mispredict, output, 1: registered one-cycle pulse on a wrong prediction.
REQ-013 Port stall, output, 1: registered; 1 when all DEPTH entries are occupied.
REQ-014 Port resolved_cnt, output, CW: count of accepted resolutions.
REQ-015 Port mispredict_cnt, output, CW: count of mispredictions.
REQ-016 Port proto_err, output, 1: sticky flag for exec_valid with no entry outstanding.

Function
REQ-017 Storage SHALL be a circular queue of DEPTH 1-bit prediction entries, with head/tail pointers wrapping modulo DEPTH and a count 0..DEPTH.
REQ-018 pred_request SHALL be combinational: fetch_branch & ~stall.
REQ-019 Allocation: when pred_request=1 at edge N, the block SHALL allocate the tail entry and mark it capture-pending.
REQ-020 Capture: at edge N+1 the block SHALL write the prediction input into the capture-pending entry and clear the pending mark.
REQ-021 Back-to-back allocations on consecutive cycles SHALL each capture correctly.
REQ-022 Resolve: an edge with exec_valid=1 and count>0 SHALL pop the head entry.
REQ-023 Bypass: if the head entry is still capture-pending at resolve, the comparison SHALL use the prediction input directly.
REQ-024 On each resolve, the block SHALL drive result=1 and taken=exec_taken in the next cycle, and 0 otherwise.
REQ-025 On each resolve, the block SHALL increment resolved_cnt, saturating at all-ones.
REQ-026 A resolve whose head prediction differs from exec_taken SHALL produce mispredict=1 in the next cycle.
REQ-027 The same mispredicting resolve SHALL increment mispredict_cnt, saturating at all-ones.
REQ-028 The same mispredicting resolve SHALL empty the queue (count=0, head=tail).
REQ-029 The mispredict flush SHALL also discard any allocation at the same edge and any pending capture.
REQ-030 pred_request SHALL still assert combinationally during a flush cycle.
REQ-031 exec_valid=1 with count=0 SHALL be ignored: no pop, no result pulse, and proto_err set to 1.
REQ-032 stall SHALL be derived from the registered count; an allocation and a resolve at the same edge while full SHALL pop only, leaving count=DEPTH-1.
REQ-033 A simultaneous allocation and correct resolve when not full SHALL leave count unchanged.
REQ-034 A single edge SHALL see at most one allocation and one resolve.

Reset
REQ-035 While rst_n=0, independent of clk, the block SHALL hold queue empty, pointers 0 and no capture pending.
REQ-036 While rst_n=0, the block SHALL hold result, taken, mispredict, stall, proto_err and both counters at 0.
REQ-037 While rst_n=0, pred_request SHALL be 0, gated by reset.
REQ-038 Reset asserted mid-operation SHALL discard all in-flight entries and any pending capture.
REQ-039 Operation SHALL resume on the first rising edge after rst_n returns to 1.

Verification
REQ-040 Fetch 1 branch with prediction=1 the next cycle, then exec_valid with exec_taken=1 -> result=1, taken=1, mispredict=0, resolved_cnt=1.
REQ-041 Fetch on 5 consecutive cycles with DEPTH=4 -> stall=1 after the 4th allocation and pred_request=0 on the 5th; count stays 4.
REQ-042 3 entries queued with predictions 1,1,0; resolve with exec_taken=0 -> mispredict=1, mispredict_cnt=1, queue empty, stall=0.
REQ-043 exec_valid the cycle after the only allocation (head pending, prediction=0, exec_taken=0) -> bypass compare, mispredict=0.
REQ-044 exec_valid with the queue empty -> no result pulse and proto_err=1 until reset.
REQ-045 rst_n low mid-stream with 2 entries queued -> all outputs 0 immediately; after release, a fresh fetch/resolve works and resolved_cnt restarts from 0.

Source files
------------

// File: rtl/branch_resolver.sv
// -----------------------------------------------------------------------------
// branch_resolver
//
// Tracks in-flight conditional branches between the predictor and the execute
// stage. Each fetched branch allocates one slot in a circular queue; the
// predictor's answer arrives one cycle later and is captured into that slot.
// When execute resolves the oldest branch, the stored prediction is compared
// with the real outcome. The block then trains the predictor, keeps hit/miss
// statistics and flushes the queue on a misprediction.
//
// Parameters
//   DEPTH          number of in-flight entries (power of two, 2..16)
//   CW             width of the statistics counters
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   fetch_branch   front end wants a prediction for a new branch this cycle
//   pred_request   combinational strobe to the predictor (fetch and not stalled)
//   prediction     predictor answer, valid the cycle after pred_request
//   exec_valid     execute resolves the oldest in-flight branch this cycle
//   exec_taken     actual outcome of that branch (1 = taken)
//   result         registered one-cycle pulse: train the predictor
//   taken          registered training outcome, meaningful while result = 1
//   mispredict     registered one-cycle pulse on a wrong prediction
//   stall          registered: all DEPTH entries are occupied
//   resolved_cnt   saturating count of accepted resolutions
//   mispredict_cnt saturating count of mispredictions
//   proto_err      sticky: exec_valid arrived with nothing outstanding
// -----------------------------------------------------------------------------
module branch_resolver #(
  parameter int DEPTH = 4,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fetch_branch,
  output logic          pred_request,
  input  logic          prediction,
  input  logic          exec_valid,
  input  logic          exec_taken,
  output logic          result,
  output logic          taken,
  output logic          mispredict,
  output logic          stall,
  output logic [CW-1:0] resolved_cnt,
  output logic [CW-1:0] mispredict_cnt,
  output logic          proto_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW = $clog2(DEPTH + 1);
  localparam logic [NW-1:0] FULL = NW'(DEPTH);

  // Queue storage and bookkeeping
  logic [DEPTH-1:0] pred_q;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [NW-1:0]    count;
  logic             pend;       // an entry is waiting for its prediction
  logic [PW-1:0]    pend_idx;   // which entry that is

  logic             alloc;
  logic             resolve;
  logic             head_pred;
  logic             flush;

  logic [PW-1:0]    head_next;
  logic [PW-1:0]    tail_next;
  logic [NW-1:0]    count_next;
  logic             pend_next;

  // Reset gates the request so the predictor sees nothing while held in reset.
  assign pred_request = fetch_branch & ~stall & rst_n;
  assign alloc        = pred_request;
  assign resolve      = exec_valid & (count != '0);

  // The head may be the entry whose prediction is arriving right now; in that
  // case the stored bit is stale, so compare against the live input instead.
  assign head_pred = (pend && (pend_idx == head)) ? prediction : pred_q[head];
  assign flush     = resolve & (head_pred != exec_taken);

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    head_next  = head;
    tail_next  = tail;
    count_next = count;
    pend_next  = 1'b0;
    if (flush) begin
      // Everything younger than the mispredicted branch is on the wrong path,
      // including a branch being allocated at this very edge.
      head_next  = tail;
      count_next = '0;
    end else begin
      if (resolve) head_next = head + 1'b1;
      if (alloc) begin
        tail_next = tail + 1'b1;
        pend_next = 1'b1;
      end
      // Full queue stalls allocation, so this never exceeds DEPTH.
      count_next = count + NW'(alloc) - NW'(resolve);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      pend           <= 1'b0;
      pend_idx       <= '0;
      result         <= 1'b0;
      taken          <= 1'b0;
      mispredict     <= 1'b0;
      stall          <= 1'b0;
      resolved_cnt   <= '0;
      mispredict_cnt <= '0;
      proto_err      <= 1'b0;
    end else begin
      head       <= head_next;
      tail       <= tail_next;
      count      <= count_next;
      pend       <= pend_next;
      pend_idx   <= alloc ? tail : pend_idx;
      result     <= resolve;
      taken      <= resolve & exec_taken;
      mispredict <= flush;
      stall      <= (count_next == FULL);
      if (resolve && (resolved_cnt != '1))
        resolved_cnt <= resolved_cnt + 1'b1;
      if (flush && (mispredict_cnt != '1))
        mispredict_cnt <= mispredict_cnt + 1'b1;
      if (exec_valid && (count == '0))
        proto_err <= 1'b1;
    end
  end

  // NOTE: the prediction array has no reset; a slot is only read after it was
  // allocated, and a pending slot is bypassed from the live input.
  always_ff @(posedge clk) begin
    if (pend && !flush)
      pred_q[pend_idx] <= prediction;
  end

endmodule
